window_pixel_streamer: RTL

//  Transmit side of the classifier pixel interface. Scans a stored frame as overlapping WINxWIN windows, raster order, stride STRIDE.

---
 rtl/face_detect_pkg.sv | 30 +++
 rtl/window_pixel_streamer_if.sv | 26 ++
 rtl/window_addr_gen.sv | 72 +++++++
 rtl/window_pixel_streamer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/face_detect_pkg.sv
// Shared types and constants for the window pixel streamer.
package face_detect_pkg;

  // Width of the column index and of the window-origin coordinates.
  localparam int ADDR_W = 9;

  // Default window side, pixels.
  localparam int WIN_DEFAULT = 20;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_HOLD,
    ST_FINISH
  } stream_state_e;

  // Origin of the last window along one axis. The division floors, so any
  // partial stride at the far edge of the frame is dropped.
  function automatic int last_origin(input int img, input int win, input int stride);
    return ((img - win) / stride) * stride;
  endfunction

endpackage

// File: rtl/window_pixel_streamer_if.sv
// Pixel beat stream from the window streamer to the classifier.
interface window_pixel_streamer_if;
  import face_detect_pkg::*;

  logic              VALID;
  logic              READY;
  logic [ADDR_W-1:0] ADDR;
  logic [7:0]        VGA_R;
  logic [7:0]        VGA_G;
  logic [7:0]        VGA_B;
  logic [ADDR_W-1:0] WIN_X;
  logic [ADDR_W-1:0] WIN_Y;
  logic              ROW_LAST;
  logic              WIN_LAST;

  modport master (
    output VALID, ADDR, VGA_R, VGA_G, VGA_B, WIN_X, WIN_Y, ROW_LAST, WIN_LAST,
    input  READY
  );

  modport slave (
    input  VALID, ADDR, VGA_R, VGA_G, VGA_B, WIN_X, WIN_Y, ROW_LAST, WIN_LAST,
    output READY
  );

endinterface

// File: rtl/window_addr_gen.sv
// Window scan counters: column, row, window origin and the frame-buffer
// row base, which is kept incrementally so no multiplier is needed.
module window_addr_gen #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int WIN    = face_detect_pkg::WIN_DEFAULT,
  parameter int STRIDE = 4,
  parameter int MEM_AW = 17
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              clear,
  input  logic                              advance,
  output logic [MEM_AW-1:0]                 mem_addr,
  output logic [face_detect_pkg::ADDR_W-1:0] col,
  output logic [face_detect_pkg::ADDR_W-1:0] win_x,
  output logic [face_detect_pkg::ADDR_W-1:0] win_y,
  output logic                              row_last,
  output logic                              win_last,
  output logic                              frame_last
);
  import face_detect_pkg::*;

  localparam int X_LAST = last_origin(IMG_W, WIN, STRIDE);
  localparam int Y_LAST = last_origin(IMG_H, WIN, STRIDE);

  logic [ADDR_W-1:0] row;
  logic [MEM_AW-1:0] row_base;  // (win_y + row) * IMG_W
  logic [MEM_AW-1:0] win_base;  // win_y * IMG_W

  assign row_last   = (col == ADDR_W'(WIN - 1));
  assign win_last   = row_last && (row == ADDR_W'(WIN - 1));
  assign frame_last = win_last && (win_x == ADDR_W'(X_LAST)) && (win_y == ADDR_W'(Y_LAST));
  assign mem_addr   = row_base + MEM_AW'(win_x) + MEM_AW'(col);

  // Step col -> row -> win_x -> win_y; the counters park on the final pixel
  // so the read address only moves again when a new scan is cleared in.
  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    if (RESET || clear) begin
      col      <= '0;
      row      <= '0;
      win_x    <= '0;
      win_y    <= '0;
      row_base <= '0;
      win_base <= '0;
    end else if (advance && !frame_last) begin
      if (!row_last) begin
        col <= col + 1'b1;
      end else begin
        col <= '0;
        if (row != ADDR_W'(WIN - 1)) begin
          row      <= row + 1'b1;
          row_base <= row_base + MEM_AW'(IMG_W);
        end else begin
          row <= '0;
          if (win_x != ADDR_W'(X_LAST)) begin
            win_x    <= win_x + ADDR_W'(STRIDE);
            row_base <= win_base;
          end else begin
            win_x    <= '0;
            win_y    <= win_y + ADDR_W'(STRIDE);
            win_base <= win_base + MEM_AW'(STRIDE * IMG_W);
            row_base <= win_base + MEM_AW'(STRIDE * IMG_W);
          end
        end
      end
    end
  end

endmodule

// File: rtl/window_pixel_streamer.sv
// Scans a stored frame as overlapping windows and streams each window row by
// row to the classifier, one beat per ISSUE/CAPTURE/HOLD round trip.
module window_pixel_streamer #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int WIN    = face_detect_pkg::WIN_DEFAULT,
  parameter int STRIDE = 4,
  parameter int MEM_AW = 17
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   START,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [MEM_AW-1:0]      MEM_ADDR,
  input  logic [23:0]            MEM_RDATA,
  window_pixel_streamer_if.master px
);
  import face_detect_pkg::*;

  stream_state_e     state;
  stream_state_e     state_nxt;
  logic              clear;
  logic              advance;
  logic              valid;

  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] win_x;
  logic [ADDR_W-1:0] win_y;
  logic              row_last;
  logic              win_last;
  logic              frame_last;

  pixel_t            pix_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] win_x_q;
  logic [ADDR_W-1:0] win_y_q;
  logic              row_last_q;
  logic              win_last_q;

  window_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .WIN    (WIN),
    .STRIDE (STRIDE),
    .MEM_AW (MEM_AW)
  ) u_addr_gen (
    .CLK        (CLK),
    .RESET      (RESET),
    .clear      (clear),
    .advance    (advance),
    .mem_addr   (MEM_ADDR),
    .col        (col),
    .win_x      (win_x),
    .win_y      (win_y),
    .row_last   (row_last),
    .win_last   (win_last),
    .frame_last (frame_last)
  );

  // State register; reset aborts any scan in progress.
  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and per-state control outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_nxt = state;
    clear     = 1'b0;
    advance   = 1'b0;
    valid     = 1'b0;
    BUSY      = (state != ST_IDLE);
    DONE      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (START) begin
          state_nxt = ST_ISSUE;
          clear     = 1'b1;
        end
      end
      ST_ISSUE:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_HOLD;
      ST_HOLD: begin
        valid = 1'b1;
        if (px.READY) begin
          advance   = 1'b1;
          state_nxt = frame_last ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_FINISH: begin
        DONE      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture the read data and beat descriptors; they stay frozen through HOLD.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pix_q      <= '0;
      addr_q     <= '0;
      win_x_q    <= '0;
      win_y_q    <= '0;
      row_last_q <= 1'b0;
      win_last_q <= 1'b0;
    end else if (state == ST_CAPTURE) begin
      pix_q      <= pixel_t'(MEM_RDATA);
      addr_q     <= col;
      win_x_q    <= win_x;
      win_y_q    <= win_y;
      row_last_q <= row_last;
      win_last_q <= win_last;
    end
  end

  assign px.VALID    = valid;
  assign px.ADDR     = addr_q;
  assign px.VGA_R    = pix_q.r;
  assign px.VGA_G    = pix_q.g;
  assign px.VGA_B    = pix_q.b;
  assign px.WIN_X    = win_x_q;
  assign px.WIN_Y    = win_y_q;
  assign px.ROW_LAST = row_last_q;
  assign px.WIN_LAST = win_last_q;

endmodule
